exercise_1b: RTL and testbench

Clocked 4-input Boolean function evaluator. On every clock edge it samples inputs A, B, C, D, evaluates a fixed single-output switching function, and presents the result on f. Used as a glue-logic cell wherever a 4-variable decoded condition is needed with a registered, glitch-free output. The function is held in a 16-entry truth-table parameter, so the same block can be re-instanced for other functions.

---
 rtl/exercise_1b.sv | 42 ++++
 tb/tb_exercise_1b.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/exercise_1b.sv
// Registered 4-input Boolean function evaluator.
// f is a truth-table lookup of {A,B,C,D}, with A as the MSB of the index.
module exercise_1b #(
    parameter logic [15:0] TRUTH_TABLE = 16'hC3AA
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic f,
    output logic f_valid
);

    logic [3:0] idx;
    logic       f_d;
    logic       f_q;
    logic       f_valid_d;
    logic       f_valid_q;

    assign idx = {A, B, C, D};

    // An X/Z on any input makes idx unknown, so the lookup yields X in simulation.
    always_comb begin
        f_d       = TRUTH_TABLE[idx];
        f_valid_d = 1'b1;
        if (rst) begin
            f_d       = 1'b0;
            f_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        f_q       <= f_d;
        f_valid_q <= f_valid_d;
    end

    assign f       = f_q;
    assign f_valid = f_valid_q;

endmodule

// File: tb/tb_exercise_1b.sv
// Self-checking bench for exercise_1b.
// Checks the default-table instance and a TRUTH_TABLE = 16'h8000 instance side by side.
module tb_exercise_1b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b1;
    logic B = 1'b1;
    logic C = 1'b1;
    logic D = 1'b1;
    logic f_def;
    logic f_def_valid;
    logic f_ovr;
    logic f_ovr_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exercise_1b dut_def (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .f       (f_def),
        .f_valid (f_def_valid)
    );

    exercise_1b #(.TRUTH_TABLE(16'h8000)) dut_ovr (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .f       (f_ovr),
        .f_valid (f_ovr_valid)
    );

    // Default function written as its minimised sum of products: A'D + AB'C' + ABC.
    function automatic logic model_default(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3];
        b = v[2];
        c = v[1];
        d = v[0];
        return (!a && d) || (a && !b && !c) || (a && b && c);
    endfunction

    // The override table is true only for the all-ones vector.
    function automatic logic model_override(input logic [3:0] v);
        return (v == 4'd15);
    endfunction

    task automatic check(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one vector at the falling edge, then check all outputs just after the rising edge.
    task automatic step(input string tag, input logic r, input logic [3:0] v);
        logic exp_def;
        logic exp_ovr;
        logic exp_valid;
        @(negedge clk);
        rst = r;
        {A, B, C, D} = v;
        exp_def   = r ? 1'b0 : model_default(v);
        exp_ovr   = r ? 1'b0 : model_override(v);
        exp_valid = !r;
        @(posedge clk);
        #1;
        $display("[TB] %s rst=%0b idx=%0d f=%b f_valid=%b f_ovr=%b f_ovr_valid=%b", tag, r, v,
                 f_def, f_def_valid, f_ovr, f_ovr_valid);
        check({tag, " f"}, f_def, exp_def);
        check({tag, " f_valid"}, f_def_valid, exp_valid);
        check({tag, " f_ovr"}, f_ovr, exp_ovr);
        check({tag, " f_ovr_valid"}, f_ovr_valid, exp_valid);
    endtask

    initial begin
        logic [3:0] v;
        logic       r;

        // Reset held for two edges with all inputs high.
        step("reset0", 1'b1, 4'b1111);
        step("reset1", 1'b1, 4'b1111);

        // Exhaustive ascending sweep.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step("sweep", 1'b0, v);
        end

        // Boundary vectors back to back; one-cycle latency is checked by step.
        step("bound0", 1'b0, 4'd0);
        step("bound15", 1'b0, 4'd15);
        step("bound8", 1'b0, 4'd8);
        step("bound10", 1'b0, 4'd10);

        // Sweep interrupted by a one-cycle reset during idx 9, then idx 14.
        for (int i = 0; i < 9; i++) begin
            v = 4'(i);
            step("presweep", 1'b0, v);
        end
        step("midreset9", 1'b1, 4'd9);
        step("resume14", 1'b0, 4'd14);

        // f must hold while D toggles between edges, then capture D at the edge.
        step("hold_base", 1'b0, 4'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            D = ~D;
            #1;
            check("hold_between_edges", f_def, 1'b0);
        end
        D = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] hold_capture D=1 f=%b", f_def);
        check("hold_capture", f_def, 1'b1);
        check("hold_capture_valid", f_def_valid, 1'b1);

        // Random vectors with occasional reset.
        for (int i = 0; i < 48; i++) begin
            v = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 7) == 0);
            step("random", r, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
